// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths, FSM state codes, output select
// codes and the opcode constants used to build instruction words.
package cpu_pkg;

  // Default instruction word width and fetch/load address width.
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 5;

  // Program memory FSM state encoding.
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_LOAD = 1'b1;

  // Source selection for the registered fetch data output.
  localparam logic [1:0] SEL_ZERO = 2'd0;  // reset value, nothing fetched yet
  localparam logic [1:0] SEL_NOP  = 2'd1;  // out-of-range address
  localparam logic [1:0] SEL_RAM  = 2'd2;  // RAM read register

  // Opcode field (top nibble of an instruction word).
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_BEQ  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Assemble an instruction word from opcode and 12-bit operand field.
  function automatic logic [DATA_W_DEF-1:0] mk_instr(input logic [3:0]  op,
                                                     input logic [11:0] arg);
    return {op, arg};
  endfunction

  // Word returned for fetches beyond the implemented depth.
  localparam logic [DATA_W_DEF-1:0] NOP_WORD_DEF = mk_instr(OP_NOP, 12'h000);

endpackage

// File: rtl/pm_ram.sv
// Simple dual-port program RAM: one synchronous write port, one synchronous
// read port with read enable. Contents are zero at power-up and are never
// cleared by reset, so the array maps onto block or distributed RAM.
module pm_ram
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] r_rd_data = '0;

  // Write port: the caller guarantees i_wr_addr < DEPTH when enabled.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read port: the read register holds its value when no read is enabled.
  always_ff @(posedge clk) begin
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/prog_mem_loadable.sv
// Loadable program memory: one-cycle fetch port for the CPU front end plus a
// streaming load port that rewrites the program at run time. Fetches are
// blocked while a load is in progress, so reads never collide with writes.
module prog_mem_loadable
  import cpu_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DEPTH    = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_busy,
  output logic              load_done
);

  // DEPTH expressed at load_len width; ADDR_W+1 bits hold 2**ADDR_W exactly.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W:0]   r_remaining;
  logic              r_fetch_ready;
  logic              r_fetch_valid;
  logic [1:0]        r_data_sel;
  logic              r_load_busy;
  logic              r_load_done;

  logic              w_in_range;
  logic              w_fetch_acc;
  logic              w_rd_en;
  logic              w_wr_en;
  logic              w_last_word;
  logic [ADDR_W:0]   w_eff_len;
  logic [DATA_W-1:0] w_ram_rd_data;
  logic [DATA_W-1:0] w_fetch_data;

  // Address guard: unsigned compare of the PC against the implemented depth.
  assign w_in_range  = ({1'b0, fetch_addr} < DEPTH_L);
  assign w_fetch_acc = (r_state == ST_RUN) && fetch_req;
  // Out-of-range fetches never touch the RAM; the output mux supplies NOP.
  assign w_rd_en     = w_fetch_acc && w_in_range && !rst;
  // Lengths beyond the array are clipped so the write pointer stays in range.
  assign w_eff_len   = (load_len > DEPTH_L) ? DEPTH_L : load_len;
  // A reset cycle must not commit a word, even if load_valid is high.
  assign w_wr_en     = (r_state == ST_LOAD) && load_valid && !rst;
  assign w_last_word = (r_remaining == (ADDR_W+1)'(1));

  pm_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (load_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (fetch_addr),
    .o_rd_data (w_ram_rd_data)
  );

  // Load FSM: RUN serves fetches, LOAD streams words into the RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_wr_ptr      <= '0;
      r_remaining   <= '0;
      r_fetch_ready <= 1'b1;
      r_load_busy   <= 1'b0;
      r_load_done   <= 1'b0;
    end else begin
      r_load_done <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (load_start) begin
            if (load_len == '0) begin
              // Empty load: acknowledge immediately, no state change.
              r_load_done <= 1'b1;
            end else begin
              r_state       <= ST_LOAD;
              r_wr_ptr      <= '0;
              r_remaining   <= w_eff_len;
              r_fetch_ready <= 1'b0;
              r_load_busy   <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          // load_start is deliberately ignored here.
          if (load_valid) begin
            r_remaining <= r_remaining - (ADDR_W+1)'(1);
            if (w_last_word) begin
              // Park the pointer at 0 so it never steps past DEPTH-1.
              r_state       <= ST_RUN;
              r_wr_ptr      <= '0;
              r_fetch_ready <= 1'b1;
              r_load_busy   <= 1'b0;
              r_load_done   <= 1'b1;
            end else begin
              r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
          end
        end
        default: begin
          r_state       <= ST_RUN;
          r_wr_ptr      <= '0;
          r_remaining   <= '0;
          r_fetch_ready <= 1'b1;
          r_load_busy   <= 1'b0;
        end
      endcase
    end
  end

  // Fetch response: valid one cycle after an accepted request; the data
  // source selection only changes on an accepted request so data holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_valid <= 1'b0;
      r_data_sel    <= SEL_ZERO;
    end else begin
      r_fetch_valid <= w_fetch_acc;
      if (w_fetch_acc) begin
        r_data_sel <= w_in_range ? SEL_RAM : SEL_NOP;
      end
    end
  end

  // Output data mux between zero, NOP and the RAM read register.
  always_comb begin
    w_fetch_data = '0;
    case (r_data_sel)
      SEL_ZERO: w_fetch_data = '0;
      SEL_NOP:  w_fetch_data = NOP_WORD;
      SEL_RAM:  w_fetch_data = w_ram_rd_data;
      default:  w_fetch_data = '0;
    endcase
  end

  assign fetch_ready = r_fetch_ready;
  assign fetch_valid = r_fetch_valid;
  assign fetch_data  = w_fetch_data;
  assign load_busy   = r_load_busy;
  assign load_done   = r_load_done;

endmodule
